mem_arbiter: RTL
================

# mem_arbiter

Round-robin arbiter that shares one word-wide memory port between up to NUM_REQ cache controllers, for example instruction and data caches or per-core caches of the mini-GPU. Each requester side uses the same level-held rd/wr plus ready-pulse protocol that the caches already drive toward memory. The arbiter owns the downstream memory port exclusively, runs one transaction at a time, and aborts hung transactions with a watchdog.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- TIMEOUT, 64, max BUSY cycles waiting for mem_ready; 0 disables the watchdog

Ports (vectors are flattened; requester i occupies slice [i*W +: W]):
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address
- req_rd  in  NUM_REQ  read request, held until req_ready
- req_wr  in  NUM_REQ  write request, held until req_ready
- req_wdata  in  NUM_REQ*DATA_WIDTH  write data
- req_rdata  out  NUM_REQ*DATA_WIDTH  read data, registered, held until the next response to that requester
- req_ready  out  NUM_REQ  one-cycle completion pulse, one-hot or zero
- req_err  out  NUM_REQ  valid with req_ready; 1 = timed out
- mem_addr  out  ADDR_WIDTH  memory address
- mem_rd  out  1  memory read strobe, level
- mem_wr  out  1  memory write strobe, level
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion
- grant  out  NUM_REQ  one-hot owner of the current transaction; 0 in IDLE
- busy  out  1  state != IDLE

## Operation
State machine with three states: IDLE, BUSY, RESP.

- **IDLE**
  - Requester i is pending when req_rd[i] | req_wr[i].
  - Winner: the first pending index scanning last_grant+1, last_grant+2, … with wrap modulo NUM_REQ.
  - On the edge the winner is chosen: latch addr, wdata and op into mem_*; set mem_wr=1 if req_wr, else mem_rd=1. Both rd and wr high means a write (rd ignored).
  - Set grant to the winner's one-hot, clear the watchdog counter, go to BUSY.
  - With no request pending, stay in IDLE with all strobes 0.
- **BUSY**
  - mem_addr, mem_wdata, mem_rd, mem_wr and grant are held stable. Requester inputs are not re-sampled.
  - On mem_ready:
    - If a read, write mem_rdata into req_rdata[g].
    - Set req_ready[g]=1, req_err[g]=0, clear mem_rd/mem_wr, set last_grant=g, go to RESP.
  - Otherwise the counter increments. When TIMEOUT≠0 and the counter reaches TIMEOUT-1 without mem_ready:
    - Clear the strobes.
    - Set req_ready[g]=1, req_err[g]=1, req_rdata[g]=0.
    - Set last_grant=g, go to RESP.
- **RESP**
  - One cycle only; the req_ready pulse is visible here. Requests are ignored.
  - On exit: req_ready and req_err return to 0, grant=0, go to IDLE.
  - This cycle gives the requester the edge it needs to drop or replace its request before the next arbitration.
- **Other rules**
  - mem_ready is ignored outside BUSY.
  - Write completions do not change req_rdata.
  - Watchdog counter width is $clog2(TIMEOUT+1); it saturates and never wraps.

## Timing
- **Reset** (asynchronous, immediate, including mid-transaction):
  - State IDLE; all outputs 0 (mem_*, req_rdata, req_ready, req_err, grant, busy).
  - last_grant=NUM_REQ-1, so requester 0 wins first. Counter 0.
  - An in-flight memory access is abandoned with no response.
- **Latency:**
  - Request sampled at edge E0 → mem strobe high from E0.
  - mem_ready sampled at edge Ek → req_ready high for the cycle after Ek.
  - IDLE one cycle later.
- **Minimum occupancy** is 3 cycles per transaction (BUSY 1, RESP 1, IDLE 1 arbitration). Back-to-back grants are 3 cycles apart.
- **Fairness:** a continuously-requesting requester waits at most NUM_REQ-1 transactions.
- **Strobes:** mem_rd and mem_wr are never high together, and never high outside BUSY.
- **One-hot rules:** at most one req_ready bit is high in any cycle; grant is one-hot in BUSY and RESP.

## Test plan
- **Single read:** req_rd[1]=1, addr 0x0000_0040; memory returns 0xDEAD_BEEF after 3 cycles.
  - mem_rd=1 with mem_addr=0x40 for 3 BUSY cycles.
  - req_ready[1] pulses 1 cycle with req_rdata[1]=0xDEADBEEF, req_err[1]=0.
- **Round-robin:** all 4 requesters read continuously; memory has zero wait.
  - Grant order after reset is 0,1,2,3,0,1 with completions 3 cycles apart.
  - Dropping req 2 gives order 0,1,3,0.
- **Write priority and data:** req 0 asserts rd and wr with wdata 0x1234_5678 to addr 0x100.
  - mem_wr=1, mem_rd=0, mem_wdata=0x12345678.
  - req_rdata[0] unchanged after the req_ready pulse.
- **Timeout:** TIMEOUT=8, memory never asserts ready.
  - mem_rd falls after the 8th BUSY cycle.
  - req_ready[3]=1, req_err[3]=1, req_rdata[3]=0.
  - The next requester is granted afterwards.
- **Mid-transaction reset:** assert rst during BUSY while req 2 is granted.
  - All outputs 0 immediately; no req_ready pulse.
  - After release, with req 0 and req 2 pending, req 0 is granted first.
- **Stray mem_ready:** pulse mem_ready while in IDLE and while in RESP.
  - No req_ready, no req_rdata change, no state change.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters.
// One transaction at a time, with a watchdog that aborts hung accesses.
module mem_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]             req_rd,
  input  logic [NUM_REQ-1:0]             req_wr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ*DATA_WIDTH-1:0]  req_rdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             req_err,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic                           mem_rd,
  output logic                           mem_wr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  input  logic                           mem_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                        state_q, state_d;
  logic [IdxW-1:0]               last_q, last_d;
  logic [IdxW-1:0]               gidx_q, gidx_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]         mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]         mem_wdata_q, mem_wdata_d;
  logic                          mem_rd_q, mem_rd_d;
  logic                          mem_wr_q, mem_wr_d;
  logic [NUM_REQ-1:0]            grant_q, grant_d;
  logic [NUM_REQ-1:0]            ready_q, ready_d;
  logic [NUM_REQ-1:0]            err_q, err_d;
  logic [NUM_REQ*DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic            win_valid;
  logic [IdxW-1:0] win_idx;

  // Scan starting just after the previous owner so every requester gets a turn.
  always_comb begin : p_pick
    logic [IdxW-1:0] cand;
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(last_q) + k) % NUM_REQ);
      if (!win_valid && (req_rd[cand] || req_wr[cand])) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gidx_d      = gidx_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    grant_d     = grant_q;
    ready_d     = '0;
    err_d       = '0;
    rdata_d     = rdata_q;
    case (state_q)
      StIdle: begin
        if (win_valid) begin
          mem_addr_d       = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_d      = req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
          mem_wr_d         = req_wr[win_idx];
          mem_rd_d         = ~req_wr[win_idx];
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          gidx_d           = win_idx;
          cnt_d            = '0;
          state_d          = StBusy;
        end
      end
      StBusy: begin
        if (mem_ready) begin
          if (mem_rd_q) begin
            rdata_d[gidx_q*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
          end
          ready_d[gidx_q] = 1'b1;
          mem_rd_d        = 1'b0;
          mem_wr_d        = 1'b0;
          last_d          = gidx_q;
          state_d         = StResp;
        end else if ((TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1))) begin
          rdata_d[gidx_q*DATA_WIDTH +: DATA_WIDTH] = '0;
          ready_d[gidx_q] = 1'b1;
          err_d[gidx_q]   = 1'b1;
          mem_rd_d        = 1'b0;
          mem_wr_d        = 1'b0;
          last_d          = gidx_q;
          state_d         = StResp;
        end else if (cnt_q != {CntW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        grant_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= IdxW'(NUM_REQ - 1);
      gidx_q      <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      grant_q     <= '0;
      ready_q     <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gidx_q      <= gidx_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      grant_q     <= grant_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign req_rdata = rdata_q;
  assign req_ready = ready_q;
  assign req_err   = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign grant     = grant_q;
  assign busy      = (state_q != StIdle);

endmodule
